// File: rtl/mips_cache_arbiter.sv
// mips_cache_arbiter: shares one Avalon-MM master port between the I-cache and D-cache.
// Ports: clk/rst_n, instr_* (read miss), data_* (read or byte-enabled write), avm_* (bus), busy.
// Tie-break: fixed data-first, or round-robin when CACHE_ARB_RR_EN is defined (start: RR_INIT).
module mips_cache_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_rdata,
    output logic        instr_valid,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_byteenable,
    output logic [31:0] data_rdata,
    output logic        data_valid,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        I_RSP,
        D_RSP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic        wr_q, wr_d;
    logic [31:0] instr_rdata_q, instr_rdata_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        data_valid_q, data_valid_d;
    logic        busy_q, busy_d;
    logic        prefer_i;
    logic        grant_i;

`ifdef CACHE_ARB_RR_EN
    // Pointer = 0 favours instruction; flipped towards the loser on every grant.
    logic rr_q, rr_d;
    assign prefer_i = ~rr_q;
`else
    logic unused_rr;
    assign unused_rr = RR_INIT;
    assign prefer_i  = 1'b0;
`endif

    assign grant_i = instr_req & (~data_req | prefer_i);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        read_d        = read_q;
        write_d       = write_q;
        wr_d          = wr_q;
        instr_rdata_d = instr_rdata_q;
        data_rdata_d  = data_rdata_q;
        instr_valid_d = 1'b0;
        data_valid_d  = 1'b0;
`ifdef CACHE_ARB_RR_EN
        rr_d          = rr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d = I_RD;
                    addr_d  = {instr_addr[31:2], 2'b00};
                    read_d  = 1'b1;
                    be_d    = 4'hF;
                    wr_d    = 1'b0;
`ifdef CACHE_ARB_RR_EN
                    rr_d    = 1'b1;
`endif
                end else if (data_req) begin
                    addr_d = {data_addr[31:2], 2'b00};
                    wr_d   = data_we;
`ifdef CACHE_ARB_RR_EN
                    rr_d   = 1'b0;
`endif
                    if (data_we) begin
                        state_d = D_WR;
                        write_d = 1'b1;
                        wdata_d = data_wdata;
                        be_d    = data_byteenable;
                    end else begin
                        state_d = D_RD;
                        read_d  = 1'b1;
                        be_d    = 4'hF;
                    end
                end
            end
            I_RD: begin
                if (!avm_waitrequest) begin
                    read_d  = 1'b0;
                    state_d = I_RSP;
                end
            end
            D_RD: begin
                if (!avm_waitrequest) begin
                    read_d  = 1'b0;
                    state_d = D_RSP;
                end
            end
            D_WR: begin
                if (!avm_waitrequest) begin
                    write_d = 1'b0;
                    state_d = D_RSP;
                end
            end
            // Read data is on the bus during the response cycle.
            I_RSP: begin
                instr_rdata_d = avm_readdata;
                instr_valid_d = 1'b1;
                state_d       = IDLE;
            end
            D_RSP: begin
                if (!wr_q) begin
                    data_rdata_d = avm_readdata;
                end
                data_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            wr_q          <= 1'b0;
            instr_rdata_q <= '0;
            instr_valid_q <= 1'b0;
            data_rdata_q  <= '0;
            data_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            read_q        <= read_d;
            write_q       <= write_d;
            wr_q          <= wr_d;
            instr_rdata_q <= instr_rdata_d;
            instr_valid_q <= instr_valid_d;
            data_rdata_q  <= data_rdata_d;
            data_valid_q  <= data_valid_d;
            busy_q        <= busy_d;
        end
    end

`ifdef CACHE_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= RR_INIT;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign avm_address    = addr_q;
    assign avm_read       = read_q;
    assign avm_write      = write_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = be_q;
    assign instr_rdata    = instr_rdata_q;
    assign instr_valid    = instr_valid_q;
    assign data_rdata     = data_rdata_q;
    assign data_valid     = data_valid_q;
    assign busy           = busy_q;

endmodule
